// File: rtl/video_timing_gen.sv
// Raster timing generator: position counters, syncs, active flag,
// start-of-vblank pulse and frame counter, all registered together.
module video_timing_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter int SYNC_POL = 1
) (
   input  logic        pixel_clk_in,
   input  logic        rst_in,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        active_draw_out,
   output logic        new_frame_out,
   output logic [5:0]  frame_count_out
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
   localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
   localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
   localparam logic        SP     = (SYNC_POL != 0);

   if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_size_chk
      $error("video_timing_gen: raster too large for counter widths");
   end

   logic [10:0] hcount_q, hcount_d;
   logic [9:0]  vcount_q, vcount_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        active_q, active_d;
   logic        nf_q, nf_d;
   logic [5:0]  frame_q, frame_d;

   // Next position, then every flag decoded from that next position so
   // the registered flags line up with the registered counters.
   always_comb begin
      hcount_d = hcount_q + 11'd1;
      vcount_d = vcount_q;
      if (hcount_q == H_LAST) begin
         hcount_d = '0;
         vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end
      active_d = (hcount_d < H_ACT) && (vcount_d < V_ACT);
      hsync_d  = ((hcount_d >= HS_BEG) && (hcount_d <= HS_END)) ? SP : ~SP;
      vsync_d  = ((vcount_d >= VS_BEG) && (vcount_d <= VS_END)) ? SP : ~SP;
      nf_d     = (hcount_d == H_ACT) && (vcount_d == V_ACT);
      frame_d  = frame_q + {5'd0, nf_d};
   end

   // State registers; reset parks at the last raster position so the
   // first edge after release lands on (0,0).
   always_ff @(posedge pixel_clk_in or negedge rst_in) begin
      if (!rst_in) begin
         hcount_q <= H_LAST;
         vcount_q <= V_LAST;
         hsync_q  <= ~SP;
         vsync_q  <= ~SP;
         active_q <= 1'b0;
         nf_q     <= 1'b0;
         frame_q  <= '0;
      end else begin
         hcount_q <= hcount_d;
         vcount_q <= vcount_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         active_q <= active_d;
         nf_q     <= nf_d;
         frame_q  <= frame_d;
      end
   end

   assign hcount_out      = hcount_q;
   assign vcount_out      = vcount_q;
   assign hsync_out       = hsync_q;
   assign vsync_out       = vsync_q;
   assign active_draw_out = active_q;
   assign new_frame_out   = nf_q;
   assign frame_count_out = frame_q;

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Free-running raster timing generator for the pixel clock domain. Produces the hcount/vcount raster position, sync pulses, active-region flag, a start-of-vblank frame pulse and a frame counter. It sits directly upstream of the sprite and pixel stages, which consume hcount_out/vcount_out as their hcount_in/vcount_in. Defaults give 1280x720@60 (74.25 MHz pixel clock).

Parameters:
H_ACTIVE, 1280, visible pixels per line
H_FP, 110, horizontal front porch (pixels)
H_SYNC, 40, horizontal sync width (pixels)
H_BP, 220, horizontal back porch (pixels)
V_ACTIVE, 720, visible lines per frame
V_FP, 5, vertical front porch (lines)
V_SYNC, 5, vertical sync width (lines)
V_BP, 20, vertical back porch (lines)
SYNC_POL, 1, sync polarity: 1 = syncs high during pulse, 0 = syncs low during pulse

Ports:
pixel_clk_in  input  1  pixel clock; all state on rising edge
rst_in  input  1  asynchronous, active-low reset
hcount_out  output  11  horizontal position, 0..H_TOTAL-1
vcount_out  output  10  vertical position, 0..V_TOTAL-1
hsync_out  output  1  horizontal sync
vsync_out  output  1  vertical sync
active_draw_out  output  1  high while position is inside the visible region
new_frame_out  output  1  single-cycle pulse at start of vertical blanking
frame_count_out  output  6  frame counter, wraps 63->0

Behaviour:
- Clock/reset: one clock, pixel_clk_in. rst_in is asynchronous and active-low. Assertion takes effect immediately, with no clock edge. Release is sampled on pixel_clk_in.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Reset values: hcount_out = H_TOTAL-1; vcount_out = V_TOTAL-1; active_draw_out = 0; new_frame_out = 0; frame_count_out = 0; hsync_out and vsync_out at their inactive level (0 when SYNC_POL=1, 1 when SYNC_POL=0).
- Counting: hcount increments every cycle. At H_TOTAL-1 it wraps to 0 and vcount increments. vcount wraps from V_TOTAL-1 to 0 on the same edge where hcount wraps.
- First clock edge after reset release gives (0,0). No idle cycles.
- Alignment: every output is registered and describes the same (hcount_out, vcount_out) on the same cycle. Zero latency between position and flags. No combinational output paths.
- active_draw_out: 1 iff hcount < H_ACTIVE and vcount < V_ACTIVE.
- hsync active iff hcount is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [1390,1429]. This is independent of vcount, so hsync also pulses during vblank.
- vsync active iff vcount is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. [725,729]. Asserted for entire lines.
- new_frame_out: high for exactly one cycle, when position = (H_ACTIVE, V_ACTIVE) = (1280,720).
- frame_count_out: increments on the same edge new_frame_out rises, so the new value is visible with the pulse. Modulo-64 wrap, 63 -> 0.
- Reset mid-frame: all state returns to reset values asynchronously. Resumes at (0,0) on the first edge after release. No new_frame pulse and no frame_count increment are generated by reset.
- Width rule: counter arithmetic done at output width. Parameters must satisfy H_TOTAL <= 2048 and V_TOTAL <= 1024 (elaboration-time check).

Test Plan:
- Reset then release: during reset hcount_out=1649, vcount_out=749, active_draw_out=0, new_frame_out=0, frame_count_out=0, hsync_out=vsync_out=0. First edge after release -> (0,0) with active_draw_out=1.
- Line 0 sweep: hcount 1279 -> active_draw_out=1; hcount 1280 -> 0. hsync_out=0 at 1389, 1 at 1390 and at 1429, 0 at 1430. hcount 1649 -> next cycle (0,1).
- Frame boundary: (1649,719) -> (0,720) with active_draw_out=0. (1280,720) -> new_frame_out=1 for one cycle and frame_count_out=1. vsync_out=1 over all of lines 725..729, 0 on line 730. (1649,749) -> (0,0).
- Counter wrap, with small parameters (H: 8/2/2/2, V: 4/1/1/1): run 64 frames -> frame_count_out 63 -> 0, with exactly 64 new_frame_out pulses, each one cycle wide.
- SYNC_POL=0: same sweep as line 0 -> hsync_out=0 at 1390..1429 and 1 elsewhere. vsync_out=0 at lines 725..729.
- Async reset at (500,300), asserted between clock edges -> outputs take reset values before the next edge. Release -> (0,0) on first edge, frame_count_out=0, no new_frame_out pulse.
